// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and legality helper shared by the pipelined ALU.
//   alu_op_e  : 4-bit opcode, OP_ADD (0) .. OP_CLRACC (10); 11-15 are illegal.
//   is_legal  : opcode legality given whether accumulator ops are built in.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_XOR    = 4'd2,
      OP_AND    = 4'd3,
      OP_OR     = 4'd4,
      OP_XNOR   = 4'd5,
      OP_NAND   = 4'd6,
      OP_DECA   = 4'd7,
      OP_INC2B  = 4'd8,
      OP_ACC    = 4'd9,
      OP_CLRACC = 4'd10
   } alu_op_e;

   localparam int OP_LAST = 10;

   function automatic logic is_legal(input logic [3:0] op, input logic acc_en);
      logic ok;
      ok = (op <= 4'(OP_LAST));
      if (!acc_en && (op == OP_ACC || op == OP_CLRACC)) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational signed datapath for the pipelined ALU.
//   op_i  : opcode (alu_op_e encoding)
//   a_i   : signed operand A, WIDTH bits
//   b_i   : signed operand B, WIDTH bits
//   acc_i : current accumulator, WIDTH+1 bits
//   res_o : WIDTH+1-bit result (new accumulator value for ACC/CLRACC)
//   ovf_o : signed overflow of the ACC addition
//   err_o : opcode illegal for this build; res_o is 0
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int ACC_EN = 1
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH:0]   acc_i,
   output logic [WIDTH:0]   res_o,
   output logic             ovf_o,
   output logic             err_o
);

   localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] TWO = (WIDTH+1)'(2);

   logic [WIDTH:0] ax, bx, sum;

   // Sign-extend once so ADD/SUB cannot overflow the WIDTH+1 result.
   assign ax  = {a_i[WIDTH-1], a_i};
   assign bx  = {b_i[WIDTH-1], b_i};
   assign sum = acc_i + ax;

   always_comb begin
      res_o = '0;
      ovf_o = 1'b0;
      err_o = 1'b0;
      if (!is_legal(op_i, ACC_EN != 0)) begin
         err_o = 1'b1;
      end else begin
         case (op_i)
            OP_ADD:    res_o = ax + bx;
            OP_SUB:    res_o = ax - bx;
            OP_XOR:    res_o = ax ^ bx;
            OP_AND:    res_o = ax & bx;
            OP_OR:     res_o = ax | bx;
            OP_XNOR:   res_o = ~(ax ^ bx);
            OP_NAND:   res_o = ~(ax & bx);
            OP_DECA:   res_o = ax - ONE;
            OP_INC2B:  res_o = bx + TWO;
            OP_ACC: begin
               res_o = sum;
               // Overflow: operands agree in sign but the sum does not.
               ovf_o = (acc_i[WIDTH] == ax[WIDTH]) && (sum[WIDTH] != acc_i[WIDTH]);
            end
            OP_CLRACC: res_o = '0;
            default:   err_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with valid/ready handshake,
// persistent accumulator, status flags and illegal-opcode error.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   clear               : synchronous flush of both stages and accumulator
//   in_valid/in_ready   : command handshake carrying a, b, op
//   out_valid/out_ready : result handshake carrying c, zero, neg, ovf, err
// S1 registers the command; S2 computes through alu_core and registers
// the result. The accumulator is written only as an op moves S1->S2, so
// back-to-back ACC ops see each other's result without a hazard.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int ACC_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   c,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err
);

   logic             rdy_en_q;   // held low until the first edge after reset
   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       op_q;
   logic             out_vld_q, out_vld_d;
   logic [WIDTH:0]   c_q, c_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic             s2_adv, accept, acc_we;
   logic [WIDTH:0]   res;
   logic             res_ovf, res_err;

   assign s2_adv   = !out_vld_q || out_ready;
   assign in_ready = rdy_en_q && !clear && (!s1_vld_q || s2_adv);
   assign accept   = in_valid && in_ready;

   alu_core #(
      .WIDTH  (WIDTH),
      .ACC_EN (ACC_EN)
   ) u_core (
      .op_i   (op_q),
      .a_i    (a_q),
      .b_i    (b_q),
      .acc_i  (acc_q),
      .res_o  (res),
      .ovf_o  (res_ovf),
      .err_o  (res_err)
   );

   // CLRACC's result is zero, so res is the new accumulator for both ops.
   assign acc_we = !res_err && (op_q == OP_ACC || op_q == OP_CLRACC);

   always_comb begin
      s1_vld_d  = s1_vld_q;
      out_vld_d = out_vld_q;
      c_d       = c_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      acc_d     = acc_q;
      if (clear) begin
         s1_vld_d  = 1'b0;
         out_vld_d = 1'b0;
         c_d       = '0;
         ovf_d     = 1'b0;
         err_d     = 1'b0;
         acc_d     = '0;
      end else begin
         if (s2_adv) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
               c_d   = res;
               ovf_d = res_ovf;
               err_d = res_err;
               if (acc_we) acc_d = res;
            end
         end
         // in_ready means S1 is empty or draining this edge.
         if (in_ready) s1_vld_d = in_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q  <= 1'b0;
         s1_vld_q  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         out_vld_q <= 1'b0;
         c_q       <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         acc_q     <= '0;
      end else begin
         rdy_en_q  <= 1'b1;
         s1_vld_q  <= s1_vld_d;
         out_vld_q <= out_vld_d;
         c_q       <= c_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         acc_q     <= acc_d;
         if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
         end
      end
   end

   assign out_valid = out_vld_q;
   assign c         = c_q;
   assign zero      = (c_q == '0);
   assign neg       = c_q[WIDTH];
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
   import alu_pkg::*;

   typedef struct {
      logic [3:0]        op;
      logic [4:0]        a;
      logic [4:0]        b;
      logic signed [5:0] c;
      logic              ovf;
      logic              err;
   } vec_t;

   typedef struct {
      logic signed [5:0] c;
      logic              ovf;
      logic              err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, clear, in_valid, out_ready;
   logic [4:0] a, b;
   logic [3:0] op;
   logic in_ready, out_valid, zero, neg, ovf, err;
   logic [5:0] c;

   // second instance built without accumulator ops
   logic z_in_valid, z_out_ready, z_in_ready, z_out_valid, z_zero, z_neg, z_ovf, z_err;
   logic [4:0] z_a, z_b;
   logic [3:0] z_op;
   logic [5:0] z_c;

   int checks = 0;
   int fails  = 0;
   int stalls = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(5), .ACC_EN(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
   );

   alu_pipe #(.WIDTH(5), .ACC_EN(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(z_in_valid), .in_ready(z_in_ready),
      .a(z_a), .b(z_b), .op(z_op), .out_valid(z_out_valid), .out_ready(z_out_ready),
      .c(z_c), .zero(z_zero), .neg(z_neg), .ovf(z_ovf), .err(z_err)
   );

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] o, input int va, input int vb,
                               input int vc, input logic vo, input logic ve);
      vec_t r;
      r.op = o; r.a = 5'(va); r.b = 5'(vb); r.c = 6'(vc); r.ovf = vo; r.err = ve;
      return r;
   endfunction

   function automatic exp_t ex(input vec_t v);
      exp_t e;
      e.c = v.c; e.ovf = v.ovf; e.err = v.err;
      return e;
   endfunction

   // Scoreboard: every result transfer is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !clear) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result actual=%0d required=none", $signed(c));
         end else begin
            e = sb.pop_front();
            if (c !== e.c || ovf !== e.ovf || err !== e.err ||
                zero !== (e.c == 0) || neg !== e.c[5]) begin
               fails++;
               $display("FAIL result actual c=%0d z=%b n=%b o=%b e=%b required c=%0d z=%b n=%b o=%b e=%b",
                        $signed(c), zero, neg, ovf, err, e.c, (e.c == 0), e.c[5], e.ovf, e.err);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after acceptance, in_valid left high.
   task automatic send(input vec_t v);
      int n;
      n = 0;
      in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++; stalls++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      else sb.push_back(ex(v));
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #1;
      chk(nm, sb.size(), 0);
   endtask

   vec_t tv[$];
   vec_t bp[3];

   initial begin
      int nacc, k;
      logic [5:0] c_hold;
      logic have, stable;

      tv.push_back(mk(OP_ADD,    15,  15,  30, 0, 0));
      tv.push_back(mk(OP_SUB,   -16,  15, -31, 0, 0));
      tv.push_back(mk(OP_XNOR,    5,   5,  -1, 0, 0));
      tv.push_back(mk(OP_DECA,  -16,   0, -17, 0, 0));
      tv.push_back(mk(OP_INC2B,   0,  15,  17, 0, 0));
      tv.push_back(mk(OP_XOR,     5,  -3,  -8, 0, 0));
      tv.push_back(mk(OP_AND,     5,  -3,   5, 0, 0));
      tv.push_back(mk(OP_OR,      5,  -3,  -3, 0, 0));
      tv.push_back(mk(OP_NAND,    5,  -3,  -6, 0, 0));
      tv.push_back(mk(OP_ADD,   -16, -16, -32, 0, 0));
      tv.push_back(mk(OP_SUB,     0,   0,   0, 0, 0));
      tv.push_back(mk(OP_CLRACC,  7,   7,   0, 0, 0));
      tv.push_back(mk(OP_ACC,    15,   0,  15, 0, 0));
      tv.push_back(mk(OP_ACC,    15,   0,  30, 0, 0));
      tv.push_back(mk(OP_ACC,    15,   0, -19, 1, 0));
      tv.push_back(mk(4'd12,      3,   4,   0, 0, 1));
      tv.push_back(mk(OP_ACC,     1,   0, -18, 0, 0));

      bp[0] = mk(OP_ADD, 1, 2, 3, 0, 0);
      bp[1] = mk(OP_SUB, 7, 1, 6, 0, 0);
      bp[2] = mk(OP_OR,  8, 1, 9, 0, 0);

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; op = '0;
      z_in_valid = 1'b0; z_out_ready = 1'b1; z_a = '0; z_b = '0; z_op = '0;

      // reset state
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_c", c, 0);
      chk("rst_zero", zero, 1);
      chk("rst_neg", neg, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", err, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rdy_before_first_edge", in_ready, 0);
      @(posedge clk); #1;
      chk("rdy_after_first_edge", in_ready, 1);

      // first op: latency
      send(tv[0]);
      in_valid = 1'b0;
      chk("lat_after_accept_edge", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_second_edge", out_valid, 1);
      chk("lat_c", $signed(c), 30);
      @(posedge clk); #1;

      // streamed table, one per cycle
      stalls = 0;
      for (int i = 1; i < tv.size(); i++) send(tv[i]);
      in_valid = 1'b0;
      chk("stream_no_bubble", stalls, 0);
      drain("stream_drained");

      // backpressure: 4 cycles of out_ready=0 with 3 commands offered
      out_ready = 1'b0; nacc = 0; k = 0; have = 1'b0; stable = 1'b1;
      in_valid = 1'b1; op = bp[0].op; a = bp[0].a; b = bp[0].b;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (in_ready && k < 3) begin
            sb.push_back(ex(bp[k])); k++; nacc++;
         end
         if (out_valid) begin
            if (!have) begin c_hold = c; have = 1'b1; end
            else if (c !== c_hold) stable = 1'b0;
         end
         @(posedge clk); #1;
         if (k < 3) begin op = bp[k].op; a = bp[k].a; b = bp[k].b; end
      end
      @(negedge clk);
      chk("bp_accepted", nacc, 2);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_c_stable", stable, 1);
      chk("bp_c_held", $signed(c), 3);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      drain("bp_drained");

      // clear with both stages full (acc currently -18)
      out_ready = 1'b0;
      send(mk(OP_ACC, 3, 0, -15, 0, 0));
      send(mk(OP_ACC, 3, 0, -12, 0, 0));
      clear = 1'b1; op = OP_ADD; a = 5'd1; b = 5'd1;
      @(negedge clk);
      chk("clr_in_ready", in_ready, 0);
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("clr_out_valid", out_valid, 0);
      chk("clr_c", c, 0);
      chk("clr_zero", zero, 1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(mk(OP_ACC, 1, 0, 1, 0, 0));
      in_valid = 1'b0;
      drain("clr_acc_zeroed");

      // async reset mid-stream (acc currently 1)
      send(mk(OP_ACC, 2, 0, 3, 0, 0));
      send(mk(OP_ACC, 2, 0, 5, 0, 0));
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_c", c, 0);
      sb.delete();
      @(posedge clk); #2 rst_n = 1'b1;
      #1 chk("arst_rdy_before_edge", in_ready, 0);
      @(posedge clk); #1;
      chk("arst_rdy_after_edge", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      send(mk(OP_ACC, 2, 0, 2, 0, 0));
      in_valid = 1'b0;
      drain("arst_acc_zeroed");

      // ACC_EN=0: accumulator ops are illegal
      for (int j = 9; j <= 10; j++) begin
         int n;
         z_in_valid = 1'b1; z_op = 4'(j); z_a = 5'd3; z_b = 5'd4;
         n = 0;
         @(negedge clk);
         while (!z_in_ready && n < 20) begin n++; @(negedge clk); end
         @(posedge clk); #1;
         z_in_valid = 1'b0;
         n = 0;
         @(negedge clk);
         while (!z_out_valid && n < 20) begin n++; @(negedge clk); end
         chk("noacc_out_valid", z_out_valid, 1);
         chk("noacc_err", z_err, 1);
         chk("noacc_c", z_c, 0);
         chk("noacc_zero", z_zero, 1);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
